// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream to instruction-memory loader
// Packs bytes big-endian into words and writes them from address 0 while holding the CPU.
module imem_loader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              cpu_hold
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

  logic [1:0]        state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic [ADDR_W:0]   n_q, n_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic [DATA_W-1:0] packed_word;
  logic [ADDR_W:0]   n_clamped;
  logic [ADDR_W:0]   words_inc;

  assign n_clamped = (num_words > MAX_WORDS) ? MAX_WORDS : num_words;
  assign words_inc = words_q + 1'b1;

  // First byte of each word lands in the most significant lane.
  always_comb begin
    packed_word = word_q;
    case (byte_cnt_q)
      2'd0:    packed_word[31:24] = in_data;
      2'd1:    packed_word[23:16] = in_data;
      2'd2:    packed_word[15:8]  = in_data;
      default: packed_word[7:0]   = in_data;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    words_d     = words_q;
    n_d         = n_q;
    word_d      = word_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          n_d        = n_clamped;
          words_d    = '0;
          byte_cnt_d = '0;
          word_d     = '0;
          state_d    = (n_clamped == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          word_d = packed_word;
          if (byte_cnt_q == 2'd3) begin
            byte_cnt_d  = '0;
            mem_addr_d  = words_q[ADDR_W-1:0];
            mem_wdata_d = packed_word;
            state_d     = S_WRITE;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
      end
      S_WRITE: begin
        words_d = words_inc;
        state_d = (words_inc == n_q) ? S_DONE : S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      byte_cnt_q  <= '0;
      words_q     <= '0;
      n_q         <= '0;
      word_q      <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      words_q     <= words_d;
      n_q         <= n_d;
      word_q      <= word_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign in_ready  = (state_q == S_LOAD);
  assign mem_we    = (state_q == S_WRITE);
  assign busy      = (state_q == S_LOAD) || (state_q == S_WRITE);
  assign cpu_hold  = busy;
  assign done      = (state_q == S_DONE);
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
